// File: rtl/vgg_fp_pkg.sv
// Shared fp32 types and helpers for the VGG streaming datapath.
// Provides the total-order key used by the max-pool comparators.
package vgg_fp_pkg;

    localparam int FP32_WIDTH = 32;

    typedef logic [FP32_WIDTH-1:0] fp32;

    localparam fp32 FP32_ZERO = '0;

    // Monotone unsigned key: negatives flipped, positives lifted above them.
    function automatic fp32 fp32_key(input fp32 x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

endpackage

// File: rtl/fp32_max2.sv
// Combinational fp32 max of two operands using the ordering key.
// Ties return a; NaNs are ordered by bit pattern only.
module fp32_max2
    import vgg_fp_pkg::*;
(
    input  logic [FP32_WIDTH-1:0] a,
    input  logic [FP32_WIDTH-1:0] b,
    output logic [FP32_WIDTH-1:0] result
);

    assign result = (fp32_key(a) >= fp32_key(b)) ? a : b;

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 fp32 max-pool holding one half-width row.
// Define MAXPOOL_RELU_EN to fuse a ReLU onto the pooled output.
module maxpool_2x2_stream
    import vgg_fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 56,
    parameter int IMG_HEIGHT = 56
)
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  data_valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  done
);

    localparam int HALF_W = IMG_WIDTH / 2;
    localparam int NOUT   = HALF_W * (IMG_HEIGHT / 2);
    localparam int CW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);
    localparam int KW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int OW     = (NOUT > 1) ? $clog2(NOUT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(NOUT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [OW-1:0] out_cnt;
    logic [KW-1:0] k;
    fp32           held;
    fp32           rowbuf [HALF_W];
    fp32           pair_max;
    fp32           win_max;
    fp32           pooled;

    assign k = KW'(col >> 1);

    fp32_max2 u_pair (
        .a      (held),
        .b      (data_in),
        .result (pair_max)
    );

    fp32_max2 u_win (
        .a      (rowbuf[k]),
        .b      (pair_max),
        .result (win_max)
    );

    always_comb begin
        pooled = win_max;
`ifdef MAXPOOL_RELU_EN
        if (win_max[31]) pooled = FP32_ZERO;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col       <= '0;
            row       <= '0;
            out_cnt   <= '0;
            held      <= FP32_ZERO;
            data_out  <= '0;
            valid_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            done      <= 1'b0;
            if (data_valid_in) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (!col[0]) begin
                    held <= data_in;
                end else if (row[0]) begin
                    data_out  <= pooled;
                    valid_out <= 1'b1;
                    done      <= (out_cnt == OUT_LAST);
                    out_cnt   <= (out_cnt == OUT_LAST) ? '0 : out_cnt + 1'b1;
                end
            end
        end
    end

    // Row buffer needs no reset: every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (data_valid_in && col[0] && !row[0]) begin
            rowbuf[k] <= pair_max;
        end
    end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed and random bench for maxpool_2x2_stream (4x4 and 56x56).
// Expected pixels come from a window-based reference model.
module tb_maxpool_2x2_stream;
    import vgg_fp_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        dv4, dv56, v4, v56, done4, done56;
    logic [31:0] din4, din56, dout4, dout56;

    always #5 clk = ~clk;

    maxpool_2x2_stream #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk(clk), .resetn(resetn), .data_valid_in(dv4), .data_in(din4),
        .data_out(dout4), .valid_out(v4), .done(done4)
    );

    maxpool_2x2_stream #(.DATA_WIDTH(32), .IMG_WIDTH(56), .IMG_HEIGHT(56)) dut56 (
        .clk(clk), .resetn(resetn), .data_valid_in(dv56), .data_in(din56),
        .data_out(dout56), .valid_out(v56), .done(done56)
    );

    bit          sel;
    int          W, H;
    logic [31:0] obs_d;
    logic        obs_v, obs_done;

    assign obs_d    = sel ? dout56 : dout4;
    assign obs_v    = sel ? v56 : v4;
    assign obs_done = sel ? done56 : done4;

    fp32  expq[$];
    int   pix_idx, out_no;
    logic exp_v, exp_done;
    fp32  exp_d;
    int   vectors, miscompares;

    function automatic fp32 ref_max(input fp32 a, input fp32 b);
        if (a[31] != b[31]) return a[31] ? b : a;
        if (!a[31]) return (a >= b) ? a : b;
        return (a <= b) ? a : b;
    endfunction

    function automatic fp32 ref_out(input fp32 x);
`ifdef MAXPOOL_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    task automatic load_frame(input fp32 px[$]);
        for (int r = 0; r < H / 2; r++) begin
            for (int c = 0; c < W / 2; c++) begin
                int  b;
                fp32 m;
                b = 2 * r * W + 2 * c;
                m = ref_max(ref_max(px[b], px[b+1]), ref_max(px[b+W], px[b+W+1]));
                expq.push_back(ref_out(m));
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        check("valid_out", {31'b0, obs_v}, {31'b0, exp_v});
        if (exp_v) check("data_out", obs_d, exp_d);
        check("done", {31'b0, obs_done}, {31'b0, exp_done});
    endtask

    task automatic tick(input logic v, input fp32 d);
        int r, c;
        @(negedge clk);
        check_out();
        if (sel) begin
            dv56 = v; din56 = d;
        end else begin
            dv4 = v; din4 = d;
        end
        exp_v    = 1'b0;
        exp_done = 1'b0;
        if (v) begin
            c = pix_idx % W;
            r = pix_idx / W;
            if ((c % 2 == 1) && (r % 2 == 1)) begin
                exp_v    = 1'b1;
                exp_d    = expq.pop_front();
                exp_done = (out_no == (W * H / 4) - 1);
                out_no   = (out_no + 1) % (W * H / 4);
            end
            pix_idx = (pix_idx + 1) % (W * H);
        end
    endtask

    task automatic run_frame(input fp32 px[$], input bit gaps);
        foreach (px[i]) begin
            if (gaps) begin
                for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++)
                    tick(1'b0, $urandom);
            end
            tick(1'b1, px[i]);
        end
    endtask

    task automatic flush();
        tick(1'b0, '0);
        tick(1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_out();
        resetn = 1'b0;
        dv4 = 1'b0;
        dv56 = 1'b0;
        #2;
        expq.delete();
        pix_idx  = 0;
        out_no   = 0;
        exp_v    = 1'b0;
        exp_done = 1'b0;
        check("rst_data_out", obs_d, 32'h0);
        check("rst_valid_out", {31'b0, obs_v}, 32'h0);
        check("rst_done", {31'b0, obs_done}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    fp32 ramp[$], ramp2[$], mix[$], rnd[$], part[$];
    fp32 ramp_tab[16] = '{
        32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
        32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
        32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
        32'h4150_0000, 32'h4160_0000, 32'h4170_0000, 32'h4180_0000
    };
    fp32 ramp2_tab[16] = '{
        32'h4188_0000, 32'h4190_0000, 32'h4198_0000, 32'h41A0_0000,
        32'h41A8_0000, 32'h41B0_0000, 32'h41B8_0000, 32'h41C0_0000,
        32'h41C8_0000, 32'h41D0_0000, 32'h41D8_0000, 32'h41E0_0000,
        32'h41E8_0000, 32'h41F0_0000, 32'h41F8_0000, 32'h4200_0000
    };

    initial begin
        vectors = 0; miscompares = 0;
        sel = 1'b0; W = 4; H = 4;
        pix_idx = 0; out_no = 0; exp_v = 1'b0; exp_done = 1'b0; exp_d = '0;
        dv4 = 1'b0; dv56 = 1'b0; din4 = '0; din56 = '0;
        resetn = 1'b0;
        #23;
        check("por_data_out4", dout4, 32'h0);
        check("por_data_out56", dout56, 32'h0);
        check("por_valid4", {31'b0, v4}, 32'h0);
        resetn = 1'b1;

        foreach (ramp_tab[i]) ramp.push_back(ramp_tab[i]);
        foreach (ramp2_tab[i]) ramp2.push_back(ramp2_tab[i]);

        // ramp 1..16 without gaps
        load_frame(ramp);
        run_frame(ramp, 1'b0);
        flush();

        // signed-zero and negative windows
        for (int i = 0; i < 16; i++) mix.push_back($urandom);
        mix[0] = 32'hC040_0000; mix[1] = 32'hBF80_0000;
        mix[4] = 32'hC000_0000; mix[5] = 32'h8000_0000;
        mix[2] = 32'h8000_0000; mix[3] = 32'h0000_0000;
        mix[6] = 32'hBF80_0000; mix[7] = 32'hC0A0_0000;
        load_frame(mix);
        run_frame(mix, 1'b0);
        flush();

        // ramp with random input gaps
        load_frame(ramp);
        run_frame(ramp, 1'b1);
        flush();

        // two frames back to back
        load_frame(ramp);
        load_frame(ramp2);
        run_frame(ramp, 1'b0);
        run_frame(ramp2, 1'b0);
        flush();

        // reset after 7 pixels, then a clean frame
        load_frame(ramp);
        for (int i = 0; i < 7; i++) part.push_back(ramp[i]);
        run_frame(part, 1'b0);
        do_reset();
        load_frame(ramp);
        run_frame(ramp, 1'b0);
        flush();

        // full-size random frame
        @(negedge clk);
        sel = 1'b1; W = 56; H = 56;
        pix_idx = 0; out_no = 0;
        for (int i = 0; i < 56 * 56; i++) rnd.push_back($urandom);
        load_frame(rnd);
        run_frame(rnd, 1'b0);
        flush();
        check("queue_drained", expq.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/maxpool_2x2_stream.md
Name: maxpool_2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pool stage for IEEE-754 fp32 pixels.
- Sits directly downstream of the 3x3 conv stage and consumes its raster-order data_out/valid_out_pixel stream, one output channel per instance.
- Emits an (IMG_WIDTH/2)x(IMG_HEIGHT/2) pooled frame in raster order, with a done pulse on the last pixel.
- Stores one half-width row only; no frame buffer.

Parameters:
- DATA_WIDTH, 32, pixel width; only 32 (fp32) supported.
- IMG_WIDTH, 56, input frame width; must be even and >= 2.
- IMG_HEIGHT, 56, input frame height; must be even and >= 2.

Ports:
- clk  input  1  clock.
- resetn  input  1  reset.
- data_valid_in  input  1  input pixel strobe; gaps of any length allowed.
- data_in  input  DATA_WIDTH  input pixel, raster order.
- data_out  output  DATA_WIDTH  pooled pixel; registered.
- valid_out  output  1  data_out qualifier, one-cycle pulse per pooled pixel.
- done  output  1  high together with valid_out on the last pooled pixel of a frame.

Behaviour:
- Interface: reset resetn, asynchronous, active-low; clock clk.
- Reset values: data_out=0, valid_out=0, done=0, col=0, row=0, out_cnt=0, held=0. Row buffer contents are don't-care.
- Position counters advance only on data_valid_in.
  - col wraps IMG_WIDTH-1 -> 0.
  - row increments on col wrap and wraps IMG_HEIGHT-1 -> 0.
  - Frame end needs no gap; the next frame may start on the next cycle.
- Ordering key: key(x) = x[31] ? ~x : (x | 32'h8000_0000).
  - max(a,b) = a when key(a) >= key(b), else b.
  - Effect: +0 beats -0; negatives are ordered correctly. NaNs are ordered by bit pattern only and not special-cased.
- Per accepted pixel at (row, col), k = col>>1:
  - Even col: held <= data_in.
  - Odd col, even row: rowbuf[k] <= max(held, data_in).
  - Odd col, odd row: data_out <= max(rowbuf[k], max(held, data_in)); valid_out <= 1.
- Latency: valid_out asserts exactly 1 clk after the accepted pixel at (odd row, odd col). valid_out is low in every other cycle.
- out_cnt counts emitted pixels and wraps at (IMG_WIDTH/2)*(IMG_HEIGHT/2)-1. done = valid_out & (out_cnt == last); it is registered with the same timing as valid_out.
- No backpressure; the consumer must accept every valid_out.
- Asynchronous reset mid-frame discards the partial frame. The next accepted pixel is treated as (0,0).
- rowbuf: IMG_WIDTH/2 entries. Written only on even rows, read only on odd rows, so a read and a write of the same entry never coincide.

Optional Feature:
- Macro MAXPOOL_RELU_EN.
  - Defined: fused ReLU on the output. When the selected max has bit31=1, data_out = 32'h0000_0000, which also maps -0 to +0.
  - Undefined: data_out is the raw max, including negative values.
- Timing and valid/done behaviour are identical in both builds.

Decomposition:
- Shared package (vgg_fp_pkg):
  - FP32_WIDTH=32 constant.
  - fp32 typedef.
  - fp32_key function.
  - FP32_ZERO constant.
- One combinational sub-module, fp32_max2 (a, b -> max), instantiated twice for the three-way max. The row buffer is a plain register array in this block.

Test Plan:
- 4x4 frame, pixels 1.0..16.0 (32'h3F80_0000...) in raster order, no gaps -> outputs 6.0, 8.0, 14.0, 16.0; each valid_out 1 clk after input index 5/7/13/15; done with 16.0 only.
- Mixed signs in a window {-3.0, -1.0, -2.0, -0.0} -> -0.0 (32'h8000_0000) without MAXPOOL_RELU_EN; 32'h0 with it. Window {-0.0, +0.0, -1.0, -5.0} -> +0.0.
- Same 4x4 stream with data_valid_in randomly deasserted 50% of cycles -> identical output values and order; valid_out never asserts during an input gap except the 1-clk delayed pulse.
- Two back-to-back 4x4 frames, second = first + 16.0 -> 8 outputs, done pulses twice (4th and 8th), counters wrap cleanly.
- resetn asserted after 7 pixels of a frame, then a full 4x4 frame -> exactly 4 outputs matching case 1, no stale rowbuf/held data.
- 56x56 default, random fp32 values vs reference model -> 784 outputs bit-exact, single done on the 784th.
